// File: rtl/ysyx_24090012_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24090012_mem_arbiter
// Brief    : Round-robin IFU/LSU arbiter for a single data-memory slave port,
//            one transaction in flight, with slave-hang timeout abort.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_24090012_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_valid,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_ready,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_err,

    input  logic                lsu_valid,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_ready,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_err,

    output logic                s_valid,
    output logic [ADDR_W-1:0]   s_addr,
    output logic                s_wen,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wmask,
    input  logic                s_ready,
    input  logic [DATA_W-1:0]   s_rdata,

    output logic                owner
);

    localparam int c_CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = (TIMEOUT > 0) ? c_CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]          r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_owner;
    logic                r_last_owner;
    logic                r_s_valid;
    logic [ADDR_W-1:0]   r_s_addr;
    logic                r_s_wen;
    logic [DATA_W-1:0]   r_s_wdata;
    logic [DATA_W/8-1:0] r_s_wmask;
    logic                r_ifu_ready;
    logic                r_lsu_ready;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;

    logic w_grant_any;
    logic w_grant_lsu;
    logic w_expire;

    // On a tie the master that was not served last wins; last_owner resets
    // to IFU so LSU takes the first contested grant.
    assign w_grant_any = ifu_valid | lsu_valid;
    assign w_grant_lsu = lsu_valid & (~ifu_valid | ~r_last_owner);
    assign w_expire    = (TIMEOUT != 0) && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_cnt        <= '0;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b0;
            r_s_valid    <= 1'b0;
            r_s_addr     <= '0;
            r_s_wen      <= 1'b0;
            r_s_wdata    <= '0;
            r_s_wmask    <= '0;
            r_ifu_ready  <= 1'b0;
            r_lsu_ready  <= 1'b0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
        end else begin
            r_ifu_ready <= 1'b0;
            r_lsu_ready <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_grant_any) begin
                        r_state   <= c_BUSY;
                        r_s_valid <= 1'b1;
                        r_owner   <= w_grant_lsu;
                        r_cnt     <= '0;
                        if (w_grant_lsu) begin
                            r_s_addr  <= lsu_addr;
                            r_s_wen   <= lsu_wen;
                            r_s_wdata <= lsu_wdata;
                            r_s_wmask <= lsu_wmask;
                        end else begin
                            r_s_addr  <= ifu_addr;
                            r_s_wen   <= 1'b0;
                            r_s_wdata <= '0;
                            r_s_wmask <= '0;
                        end
                    end
                end
                c_BUSY: begin
                    // A slave completion in the expiry cycle still counts as success.
                    if (s_ready || w_expire) begin
                        r_state     <= c_RESP;
                        r_s_valid   <= 1'b0;
                        r_ifu_ready <= ~r_owner;
                        r_lsu_ready <= r_owner;
                        r_err       <= ~s_ready;
                        r_rdata     <= (s_ready && !r_s_wen) ? s_rdata : '0;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_RESP: begin
                    r_last_owner <= r_owner;
                    r_state      <= c_IDLE;
                end
                default: begin
                    r_state   <= c_IDLE;
                    r_s_valid <= 1'b0;
                end
            endcase
        end
    end

    assign s_valid   = r_s_valid;
    assign s_addr    = r_s_addr;
    assign s_wen     = r_s_wen;
    assign s_wdata   = r_s_wdata;
    assign s_wmask   = r_s_wmask;
    assign ifu_ready = r_ifu_ready;
    assign lsu_ready = r_lsu_ready;
    assign ifu_rdata = r_rdata;
    assign lsu_rdata = r_rdata;
    assign ifu_err   = r_err;
    assign lsu_err   = r_err;
    assign owner     = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24090012_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_24090012_mem_arbiter
// Brief    : Directed self-checking bench for the IFU/LSU memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_24090012_mem_arbiter;

    localparam int c_ADDR_W  = 32;
    localparam int c_DATA_W  = 32;
    localparam int c_TIMEOUT = 4;

    logic        clk;
    logic        rst;
    logic        ifu_valid;
    logic [31:0] ifu_addr;
    logic        ifu_ready;
    logic [31:0] ifu_rdata;
    logic        ifu_err;
    logic        lsu_valid;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_ready;
    logic [31:0] lsu_rdata;
    logic        lsu_err;
    logic        s_valid;
    logic [31:0] s_addr;
    logic        s_wen;
    logic [31:0] s_wdata;
    logic [3:0]  s_wmask;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic        owner;

    int total = 0;
    int bad   = 0;

    ysyx_24090012_mem_arbiter #(
        .ADDR_W  (c_ADDR_W),
        .DATA_W  (c_DATA_W),
        .TIMEOUT (c_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ifu_valid (ifu_valid),
        .ifu_addr  (ifu_addr),
        .ifu_ready (ifu_ready),
        .ifu_rdata (ifu_rdata),
        .ifu_err   (ifu_err),
        .lsu_valid (lsu_valid),
        .lsu_addr  (lsu_addr),
        .lsu_wen   (lsu_wen),
        .lsu_wdata (lsu_wdata),
        .lsu_wmask (lsu_wmask),
        .lsu_ready (lsu_ready),
        .lsu_rdata (lsu_rdata),
        .lsu_err   (lsu_err),
        .s_valid   (s_valid),
        .s_addr    (s_addr),
        .s_wen     (s_wen),
        .s_wdata   (s_wdata),
        .s_wmask   (s_wmask),
        .s_ready   (s_ready),
        .s_rdata   (s_rdata),
        .owner     (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are observed 1ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string name);
        int n = 0;
        while (!s_valid && n < 10) begin
            tick();
            n++;
        end
        total++;
        if (s_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s grant: s_valid=%b want 1 after %0d cycles", name, s_valid, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if ({s_valid, s_wen, ifu_ready, lsu_ready, ifu_err, lsu_err, owner} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctl: got %b want 0000000",
                     {s_valid, s_wen, ifu_ready, lsu_ready, ifu_err, lsu_err, owner});
        end
        total++;
        if ({s_addr, s_wdata, s_wmask, ifu_rdata, lsu_rdata} !== '0) begin
            bad++;
            $display("FAIL reset_data: addr=%h wdata=%h wmask=%h rdata=%h want 0",
                     s_addr, s_wdata, s_wmask, ifu_rdata);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ifu_read();
        int vcnt = 0;
        ifu_valid = 1'b1;
        ifu_addr  = 32'h8000_0000;
        tick();
        total++;
        if (s_valid !== 1'b1 || s_addr !== 32'h8000_0000 || s_wen !== 1'b0 || owner !== 1'b0) begin
            bad++;
            $display("FAIL ifu_req: valid=%b addr=%h wen=%b owner=%b want 1 80000000 0 0",
                     s_valid, s_addr, s_wen, owner);
        end
        vcnt++;
        tick();
        if (s_valid === 1'b1) vcnt++;
        s_ready = 1'b1;
        s_rdata = 32'h0000_0413;
        tick();
        s_ready = 1'b0;
        total++;
        if (vcnt !== 2 || s_valid !== 1'b0) begin
            bad++;
            $display("FAIL ifu_svalid_len: cycles=%0d s_valid=%b want 2 0", vcnt, s_valid);
        end
        total++;
        if (ifu_ready !== 1'b1 || ifu_rdata !== 32'h0000_0413 || ifu_err !== 1'b0 || lsu_ready !== 1'b0) begin
            bad++;
            $display("FAIL ifu_resp: ready=%b rdata=%h err=%b lsu_ready=%b want 1 00000413 0 0",
                     ifu_ready, ifu_rdata, ifu_err, lsu_ready);
        end
        ifu_valid = 1'b0;
        tick();
        total++;
        if (ifu_ready !== 1'b0) begin
            bad++;
            $display("FAIL ifu_pulse: ready=%b want 0", ifu_ready);
        end
        tick();
    endtask

    task automatic test_lsu_store();
        lsu_valid = 1'b1;
        lsu_addr  = 32'h8000_1000;
        lsu_wen   = 1'b1;
        lsu_wdata = 32'hDEAD_BEEF;
        lsu_wmask = 4'hF;
        tick();
        total++;
        if (s_valid !== 1'b1 || s_addr !== 32'h8000_1000 || s_wen !== 1'b1 ||
            s_wdata !== 32'hDEAD_BEEF || s_wmask !== 4'hF || owner !== 1'b1) begin
            bad++;
            $display("FAIL lsu_store_req: v=%b a=%h wen=%b d=%h m=%h own=%b want 1 80001000 1 deadbeef f 1",
                     s_valid, s_addr, s_wen, s_wdata, s_wmask, owner);
        end
        s_ready = 1'b1;
        s_rdata = 32'h1234_5678;
        tick();
        s_ready = 1'b0;
        total++;
        if (lsu_ready !== 1'b1 || lsu_rdata !== 32'h0 || lsu_err !== 1'b0 || ifu_ready !== 1'b0) begin
            bad++;
            $display("FAIL lsu_store_resp: ready=%b rdata=%h err=%b ifu_ready=%b want 1 00000000 0 0",
                     lsu_ready, lsu_rdata, lsu_err, ifu_ready);
        end
        lsu_valid = 1'b0;
        lsu_wen   = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_alternate();
        int exp_own[4] = '{1, 0, 1, 0};
        rst       = 1'b1;
        ifu_valid = 1'b1;
        ifu_addr  = 32'h8000_0100;
        lsu_valid = 1'b1;
        lsu_addr  = 32'h8000_2000;
        lsu_wen   = 1'b0;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_grant("alt");
            total++;
            if (owner !== exp_own[k][0] ||
                s_addr !== (exp_own[k] == 1 ? 32'h8000_2000 : 32'h8000_0100)) begin
                bad++;
                $display("FAIL alt_owner[%0d]: owner=%b addr=%h want owner %0d", k, owner, s_addr, exp_own[k]);
            end
            s_ready = 1'b1;
            s_rdata = 32'hA000_0000 + k;
            tick();
            s_ready = 1'b0;
            total++;
            if (ifu_ready !== (exp_own[k] == 0) || lsu_ready !== (exp_own[k] == 1) ||
                ifu_rdata !== 32'hA000_0000 + k) begin
                bad++;
                $display("FAIL alt_resp[%0d]: ifu_ready=%b lsu_ready=%b rdata=%h want owner %0d rdata %h",
                         k, ifu_ready, lsu_ready, ifu_rdata, exp_own[k], 32'hA000_0000 + k);
            end
            tick();
        end
        ifu_valid = 1'b0;
        lsu_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        int n = 0;
        lsu_valid = 1'b1;
        lsu_addr  = 32'h8000_3000;
        lsu_wen   = 1'b0;
        s_rdata   = 32'hCAFE_F00D;
        tick();
        while (s_valid && n < 20) begin
            n++;
            tick();
        end
        total++;
        if (n !== c_TIMEOUT) begin
            bad++;
            $display("FAIL timeout_len: s_valid cycles=%0d want %0d", n, c_TIMEOUT);
        end
        total++;
        if (lsu_ready !== 1'b1 || lsu_err !== 1'b1 || lsu_rdata !== 32'h0 || ifu_ready !== 1'b0) begin
            bad++;
            $display("FAIL timeout_resp: ready=%b err=%b rdata=%h ifu_ready=%b want 1 1 00000000 0",
                     lsu_ready, lsu_err, lsu_rdata, ifu_ready);
        end
        lsu_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_timeout_edge();
        lsu_valid = 1'b1;
        lsu_addr  = 32'h8000_3004;
        tick();
        tick();
        tick();
        tick();
        total++;
        if (s_valid !== 1'b1) begin
            bad++;
            $display("FAIL edge_svalid: s_valid=%b want 1 in 4th busy cycle", s_valid);
        end
        s_ready = 1'b1;
        s_rdata = 32'h5555_AAAA;
        tick();
        s_ready = 1'b0;
        total++;
        if (lsu_ready !== 1'b1 || lsu_err !== 1'b0 || lsu_rdata !== 32'h5555_AAAA) begin
            bad++;
            $display("FAIL edge_resp: ready=%b err=%b rdata=%h want 1 0 5555aaaa",
                     lsu_ready, lsu_err, lsu_rdata);
        end
        lsu_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_busy();
        ifu_valid = 1'b1;
        ifu_addr  = 32'h8000_0010;
        tick();
        total++;
        if (s_valid !== 1'b1) begin
            bad++;
            $display("FAIL midrst_busy: s_valid=%b want 1", s_valid);
        end
        rst = 1'b1;
        #1;
        total++;
        if (s_valid !== 1'b0) begin
            bad++;
            $display("FAIL midrst_async: s_valid=%b want 0", s_valid);
        end
        tick();
        total++;
        if (ifu_ready !== 1'b0 || lsu_ready !== 1'b0) begin
            bad++;
            $display("FAIL midrst_noready: ifu_ready=%b lsu_ready=%b want 0 0", ifu_ready, lsu_ready);
        end
        rst = 1'b0;
        wait_grant("midrst");
        total++;
        if (owner !== 1'b0 || s_addr !== 32'h8000_0010) begin
            bad++;
            $display("FAIL midrst_regrant: owner=%b addr=%h want 0 80000010", owner, s_addr);
        end
        s_ready = 1'b1;
        s_rdata = 32'h0000_0093;
        tick();
        s_ready = 1'b0;
        total++;
        if (ifu_ready !== 1'b1 || ifu_rdata !== 32'h0000_0093) begin
            bad++;
            $display("FAIL midrst_resp: ready=%b rdata=%h want 1 00000093", ifu_ready, ifu_rdata);
        end
        ifu_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_spurious();
        s_ready = 1'b1;
        s_rdata = 32'hFFFF_FFFF;
        tick();
        tick();
        total++;
        if (ifu_ready !== 1'b0 || lsu_ready !== 1'b0 || s_valid !== 1'b0) begin
            bad++;
            $display("FAIL spurious: ifu_ready=%b lsu_ready=%b s_valid=%b want 0 0 0",
                     ifu_ready, lsu_ready, s_valid);
        end
        s_ready   = 1'b0;
        ifu_valid = 1'b1;
        ifu_addr  = 32'h8000_0020;
        tick();
        total++;
        if (s_valid !== 1'b1 || s_addr !== 32'h8000_0020) begin
            bad++;
            $display("FAIL spurious_idle: s_valid=%b addr=%h want 1 80000020", s_valid, s_addr);
        end
        s_ready = 1'b1;
        s_rdata = 32'h0000_0013;
        tick();
        s_ready = 1'b0;
        total++;
        if (ifu_ready !== 1'b1 || ifu_rdata !== 32'h0000_0013) begin
            bad++;
            $display("FAIL spurious_resp: ready=%b rdata=%h want 1 00000013", ifu_ready, ifu_rdata);
        end
        ifu_valid = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        ifu_valid = 1'b0;
        ifu_addr  = '0;
        lsu_valid = 1'b0;
        lsu_addr  = '0;
        lsu_wen   = 1'b0;
        lsu_wdata = '0;
        lsu_wmask = '0;
        s_ready   = 1'b0;
        s_rdata   = '0;
        test_reset();
        test_ifu_read();
        test_lsu_store();
        test_alternate();
        test_timeout();
        test_timeout_edge();
        test_reset_mid_busy();
        test_spurious();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
